universal_shift_reg: RTL and testbench



---
 rtl/universal_shift_reg_pkg.sv | 11 +
 rtl/universal_shift_reg.sv | 39 +++
 tb/tb_universal_shift_reg.sv | 122 ++++++++++++
 3 files changed

// File: rtl/universal_shift_reg_pkg.sv
// Mode encodings shared by the universal shift register and anything that drives it.
package universal_shift_reg_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_HOLD = 2'b00;
    localparam sel_t SEL_SHR  = 2'b01;
    localparam sel_t SEL_SHL  = 2'b10;
    localparam sel_t SEL_LOAD = 2'b11;

endpackage

// File: rtl/universal_shift_reg.sv
// N-bit universal shift register: hold, logical shift right/left, parallel load.
// Output is the register itself; reset clears it asynchronously.
module universal_shift_reg
    import universal_shift_reg_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  sel_t         sel,
    input  logic [N-1:0] data_in,
    output logic [N-1:0] data_out
);

    logic [N-1:0] data_q;
    logic [N-1:0] data_d;

    // Next-state selection; the fill bit for both shift directions is always zero.
    always_comb begin
        data_d = data_q;
        case (sel)
            SEL_SHR:  data_d = {1'b0, data_q[N-1:1]};
            SEL_SHL:  data_d = {data_q[N-2:0], 1'b0};
            SEL_LOAD: data_d = data_in;
            default:  data_d = data_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg (N = 8): expected values are queued
// when each operation is driven and compared one edge later.
module tb_universal_shift_reg;
    import universal_shift_reg_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    sel_t         sel;
    logic [N-1:0] data_in;
    logic [N-1:0] data_out;

    logic [N-1:0] exp_q[$];
    int           errors = 0;
    int           checks = 0;

    universal_shift_reg #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: data_out=%h expected=%h", tag, act, exp);
        end
    endtask

    // Drive one operation, queue its expected result, compare after the edge.
    task automatic op(input string tag, input sel_t s, input logic [N-1:0] d, input logic [N-1:0] exp);
        logic [N-1:0] e;
        @(negedge clk);
        sel     = s;
        data_in = d;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, data_out, ~exp);
        end else begin
            e = exp_q.pop_front();
            check(tag, data_out, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: data_out=%h expected=simulation end", data_out);
        $fatal(1, "timeout");
    end

    initial begin
        sel     = SEL_HOLD;
        data_in = '0;
        rst     = 1'b1;
        #1;
        check("reset_immediate", data_out, 8'h00);

        // Reset dominates even when a load is requested.
        sel     = SEL_LOAD;
        data_in = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_held", data_out, 8'h00);
        end
        @(negedge clk);
        sel = SEL_HOLD;
        rst = 1'b0;

        op("load_AA", SEL_LOAD, 8'hAA, 8'hAA);
        op("hold_AA", SEL_HOLD, 8'h00, 8'hAA);
        op("shr_1", SEL_SHR, 8'h00, 8'h55);
        op("shr_2", SEL_SHR, 8'h00, 8'h2A);
        op("shr_3", SEL_SHR, 8'h00, 8'h15);
        op("shr_4", SEL_SHR, 8'h00, 8'h0A);
        op("shl_1", SEL_SHL, 8'h00, 8'h14);
        op("shl_2", SEL_SHL, 8'h00, 8'h28);
        op("shl_3", SEL_SHL, 8'h00, 8'h50);

        op("load_FF_r", SEL_LOAD, 8'hFF, 8'hFF);
        for (int i = 1; i <= N + 1; i++)
            op("flush_shr", SEL_SHR, 8'h00, (i >= N) ? 8'h00 : 8'(8'hFF >> i));
        op("load_FF_l", SEL_LOAD, 8'hFF, 8'hFF);
        for (int i = 1; i <= N + 1; i++)
            op("flush_shl", SEL_SHL, 8'h00, (i >= N) ? 8'h00 : 8'(8'hFF << i));

        // Reset mid-operation, asserted between clock edges.
        op("load_C3", SEL_LOAD, 8'hC3, 8'hC3);
        op("shr_C3", SEL_SHR, 8'h00, 8'h61);
        #2;
        rst = 1'b1;
        #1;
        check("reset_async", data_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        op("shl_after_rst", SEL_SHL, 8'h00, 8'h00);

        // data_in must not matter unless loading.
        op("load_3C", SEL_LOAD, 8'h3C, 8'h3C);
        op("iso_hold", SEL_HOLD, 8'($urandom), 8'h3C);
        op("iso_shr", SEL_SHR, 8'hFF, 8'h1E);
        op("iso_shl", SEL_SHL, 8'($urandom), 8'h3C);
        op("iso_hold2", SEL_HOLD, 8'hA5, 8'h3C);
        op("load_after", SEL_LOAD, 8'h81, 8'h81);
        op("shl_after_load", SEL_SHL, 8'h00, 8'h02);

        if (exp_q.size() != 0)
            check("sb_leftover", 8'(exp_q.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
